// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS execute-stage ALU (combinational, signed overflow, true SLT)
// plus an iterative one-bit-per-cycle multiply/divide unit owning HI/LO.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Overflow,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] alu_and  = 4'b0000;
  localparam logic [3:0] alu_or   = 4'b0001;
  localparam logic [3:0] alu_add  = 4'b0010;
  localparam logic [3:0] alu_sll  = 4'b0011;
  localparam logic [3:0] alu_srl  = 4'b0100;
  localparam logic [3:0] alu_sub  = 4'b0110;
  localparam logic [3:0] alu_slt  = 4'b0111;
  localparam logic [3:0] alu_addu = 4'b1000;
  localparam logic [3:0] alu_subu = 4'b1001;
  localparam logic [3:0] alu_xor  = 4'b1010;
  localparam logic [3:0] alu_sltu = 4'b1011;
  localparam logic [3:0] alu_nor  = 4'b1100;
  localparam logic [3:0] alu_sra  = 4'b1101;
  localparam logic [3:0] alu_lui  = 4'b1110;

  localparam logic [2:0] md_mult  = 3'b001;
  localparam logic [2:0] md_multu = 3'b010;
  localparam logic [2:0] md_div   = 3'b011;
  localparam logic [2:0] md_divu  = 3'b100;
  localparam logic [2:0] md_mthi  = 3'b101;
  localparam logic [2:0] md_mtlo  = 3'b110;

  typedef enum logic {idle, run} state_t;

  // ---------------- ALU ----------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff;

  assign shamt = BusA[SHW-1:0];
  assign sum   = BusA + BusB;
  assign diff  = BusA - BusB;

  // Result mux; overflow only meaningful for the trapping ADD/SUB
  always_comb begin
    BusW     = '0;
    Overflow = 1'b0;
    case (ALUCtrl)
      alu_and:  BusW = BusA & BusB;
      alu_or:   BusW = BusA | BusB;
      alu_add: begin
        BusW     = sum;
        Overflow = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      alu_sll:  BusW = BusB << shamt;
      alu_srl:  BusW = BusB >> shamt;
      alu_sub: begin
        BusW     = diff;
        Overflow = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      alu_slt:  BusW = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      alu_addu: BusW = sum;
      alu_subu: BusW = diff;
      alu_xor:  BusW = BusA ^ BusB;
      alu_sltu: BusW = {{(WIDTH-1){1'b0}}, (BusA < BusB)};
      alu_nor:  BusW = ~(BusA | BusB);
      alu_sra:  BusW = $signed(BusB) >>> shamt;
      alu_lui:  BusW = {BusB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:  BusW = '0;
    endcase
  end

  assign Zero = (BusW == '0);

  // ---------------- Multiply / divide ----------------
  state_t             state_reg, state_next;
  logic [SHW-1:0]     cnt_reg, cnt_next;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   araw_reg, araw_next;   // BusA as captured, for divide-by-zero HI
  logic               is_div_reg, is_div_next;
  logic               a_neg_reg, a_neg_next;
  logic               b_neg_reg, b_neg_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  // Operand capture: magnitudes of signed operands, raw for unsigned ops
  logic             signed_op, a_neg_in, b_neg_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign signed_op = (MDOp == md_mult) || (MDOp == md_div);
  assign a_neg_in  = signed_op & BusA[WIDTH-1];
  assign b_neg_in  = signed_op & BusB[WIDTH-1];
  assign mag_a     = a_neg_in ? -BusA : BusA;
  assign mag_b     = b_neg_in ? -BusB : BusB;

  // One shift-add step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

  // One restoring-division step; the difference always fits WIDTH bits when kept
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, div_rem;
  logic [2*WIDTH-1:0] div_step;

  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_reg;
  assign div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_step  = {div_rem, acc_reg[WIDTH-2:0], div_ge};

  // Final sign fix-ups applied to the last step's result
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign acc_step = is_div_reg ? div_step : mul_step;
  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -acc_step : acc_step;
  assign quo_fix  = (a_neg_reg ^ b_neg_reg) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem_fix  = a_neg_reg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_reg <= idle;
    else       state_reg <= state_next;
  end

  // Datapath registers; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      araw_reg   <= '0;
      is_div_reg <= 1'b0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      araw_reg   <= araw_next;
      is_div_reg <= is_div_next;
      a_neg_reg  <= a_neg_next;
      b_neg_reg  <= b_neg_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

  // Next-state: accept in idle, iterate WIDTH steps in run, write HI/LO on the last
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    araw_next   = araw_reg;
    is_div_next = is_div_reg;
    a_neg_next  = a_neg_reg;
    b_neg_next  = b_neg_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
    case (state_reg)
      idle: begin
        if (Start) begin
          case (MDOp)
            md_mult, md_multu: begin
              state_next  = run;
              cnt_next    = '0;
              acc_next    = {{WIDTH{1'b0}}, mag_b};
              opnd_next   = mag_a;
              araw_next   = BusA;
              is_div_next = 1'b0;
              a_neg_next  = a_neg_in;
              b_neg_next  = b_neg_in;
            end
            md_div, md_divu: begin
              state_next  = run;
              cnt_next    = '0;
              acc_next    = {{WIDTH{1'b0}}, mag_a};
              opnd_next   = mag_b;
              araw_next   = BusA;
              is_div_next = 1'b1;
              a_neg_next  = a_neg_in;
              b_neg_next  = b_neg_in;
            end
            md_mthi: hi_next = BusA;
            md_mtlo: lo_next = BusA;
            default: ;
          endcase
        end
      end
      run: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + SHW'(1);
        if (cnt_reg == SHW'(WIDTH-1)) begin
          state_next = idle;
          cnt_next   = '0;
          done_next  = 1'b1;
          if (!is_div_reg) begin
            {hi_next, lo_next} = prod_fix;
          end else if (opnd_reg == '0) begin
            lo_next = '1;
            hi_next = araw_reg;
          end else begin
            lo_next = quo_fix;
            hi_next = rem_fix;
          end
        end
      end
    endcase
  end

  assign Busy = (state_reg == run);
  assign Done = done_reg;
  assign Hi   = hi_reg;
  assign Lo   = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized + directed checks of alu_muldiv against an
// arithmetic reference model (WIDTH=32 instance) plus a WIDTH=8 instance.
module tb_alu_muldiv;

  localparam logic [2:0] op_mult  = 3'd1;
  localparam logic [2:0] op_multu = 3'd2;
  localparam logic [2:0] op_div   = 3'd3;
  localparam logic [2:0] op_divu  = 3'd4;
  localparam logic [2:0] op_mthi  = 3'd5;
  localparam logic [2:0] op_mtlo  = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH = 32 instance
  logic [31:0] busa = '0, busb = '0;
  logic [3:0]  aluctrl = '0;
  logic [2:0]  mdop = '0;
  logic        start = 1'b0;
  logic [31:0] busw, hi, lo;
  logic        zero, ovf, busy, done;

  alu_muldiv #(.WIDTH(32)) dut (
    .CLK(clk), .Reset(rst), .BusA(busa), .BusB(busb), .ALUCtrl(aluctrl),
    .BusW(busw), .Zero(zero), .Overflow(ovf), .MDOp(mdop), .Start(start),
    .Busy(busy), .Done(done), .Hi(hi), .Lo(lo)
  );

  // WIDTH = 8 instance
  logic [7:0] busa8 = '0, busb8 = '0;
  logic [3:0] aluctrl8 = '0;
  logic [2:0] mdop8 = '0;
  logic       start8 = 1'b0;
  logic [7:0] busw8, hi8, lo8;
  logic       zero8, ovf8, busy8, done8;

  alu_muldiv #(.WIDTH(8)) dut8 (
    .CLK(clk), .Reset(rst), .BusA(busa8), .BusB(busb8), .ALUCtrl(aluctrl8),
    .BusW(busw8), .Zero(zero8), .Overflow(ovf8), .MDOp(mdop8), .Start(start8),
    .Busy(busy8), .Done(done8), .Hi(hi8), .Lo(lo8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference ALU: returns {overflow, result}; overflow = sum does not fit 32-bit signed
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] w;
    logic        ov;
    longint      s;
    int          sh;
    w  = '0;
    ov = 1'b0;
    sh = int'(a[4:0]);
    case (c)
      4'h0: w = a & b;
      4'h1: w = a | b;
      4'h2: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        w  = s[31:0];
        ov = (s != longint'($signed(w)));
      end
      4'h3: w = b << sh;
      4'h4: w = b >> sh;
      4'h6: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        w  = s[31:0];
        ov = (s != longint'($signed(w)));
      end
      4'h7: w = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: w = a + b;
      4'h9: w = a - b;
      4'hA: w = a ^ b;
      4'hB: w = (a < b) ? 32'd1 : 32'd0;
      4'hC: w = ~(a | b);
      4'hD: begin
        s = longint'($signed(b)) >>> sh;
        w = s[31:0];
      end
      4'hE: w = {b[15:0], 16'h0000};
      default: w = '0;
    endcase
    return {ov, w};
  endfunction

  // Reference mul/div: returns {hi, lo}
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sp;
    int          q, r;
    p = '0;
    case (op)
      op_mult: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p  = sp;
      end
      op_multu: p = {32'h0, a} * {32'h0, b};
      op_div: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          p = {r, q};
        end
      end
      op_divu: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Transaction-level model: result precomputed at accept, appears 32 edges later
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
        end
      end else if (start) begin
        if (mdop >= op_mult && mdop <= op_divu) begin
          m_res  <= md_ref(mdop, busa, busb);
          m_busy <= 1'b1;
          m_cnt  <= 32;
        end else if (mdop == op_mthi) m_hi <= busa;
        else if (mdop == op_mtlo) m_lo <= busa;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (done) $display("txn complete hi=%h lo=%h", hi, lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; mdop = op; busa = a; busb = b;
    @(posedge clk); #2;
    start = 1'b0; mdop = 3'd0; busa = $urandom; busb = $urandom;
  endtask

  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cycles++;
    end
    chk("done_seen", done, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0]  t_c [10] = '{4'h2, 4'h8, 4'h7, 4'hB, 4'hD, 4'h5, 4'h6, 4'hE, 4'h3, 4'hC};
  logic [31:0] t_a [10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4,
                            32'h1234, 32'h80000000, 32'h0, 32'h24, 32'h0};
  logic [31:0] t_b [10] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h80000000,
                            32'h5678, 32'h1, 32'h0000ABCD, 32'h1, 32'h0};
  logic [31:0] t_w [10] = '{32'h80000000, 32'h80000000, 32'h1, 32'h0, 32'hF8000000,
                            32'h0, 32'h7FFFFFFF, 32'hABCD0000, 32'h10, 32'hFFFFFFFF};
  logic        t_v [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int bc;
    int n8;
    int dcount;
    logic [32:0] r;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);

    // ALU directed table
    for (int i = 0; i < 10; i++) begin
      aluctrl = t_c[i]; busa = t_a[i]; busb = t_b[i];
      #1;
      chk("alu_w", busw, t_w[i]);
      chk("alu_ovf", ovf, t_v[i]);
      chk("alu_zero", zero, (t_w[i] == 32'h0));
    end

    // WIDTH = 8: ALU spot checks and MULTU 0xFF x 0x02
    aluctrl8 = 4'h2; busa8 = 8'h7F; busb8 = 8'h01; #1;
    chk("alu8_add", busw8, 8'h80);
    chk("alu8_ovf", ovf8, 1);
    aluctrl8 = 4'hE; busb8 = 8'h34; #1;
    chk("alu8_lui", busw8, 8'h40);
    chk("alu8_zero", zero8, 0);
    @(posedge clk); #2;
    start8 = 1'b1; mdop8 = op_multu; busa8 = 8'hFF; busb8 = 8'h02;
    @(posedge clk); #2;
    start8 = 1'b0; mdop8 = 3'd0; busa8 = 8'($urandom); busb8 = 8'($urandom);
    n8 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) break;
      if (busy8) n8++;
    end
    chk("w8_done", done8, 1);
    chk("w8_latency", n8, 8);
    chk("w8_hi", hi8, 8'h01);
    chk("w8_lo", lo8, 8'hFE);
    $display("txn w8 multu hi=%h lo=%h", hi8, lo8);

    // MULT -3 x 7
    issue(op_mult, 32'hFFFFFFFD, 32'd7);
    wait_done(bc);
    chk("mult_latency", bc, 32);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    chk("model_pin_hi", m_hi, 32'hFFFFFFFF);
    chk("model_pin_lo", m_lo, 32'hFFFFFFEB);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    issue(op_multu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(bc);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(op_div, 32'hFFFFFFF9, 32'd2);
    wait_done(bc);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("model_pin_div", m_lo, 32'hFFFFFFFD);

    issue(op_divu, 32'd7, 32'd0);
    wait_done(bc);
    chk("divu0_latency", bc, 32);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd7);

    issue(op_div, 32'h80000000, 32'hFFFFFFFF);
    wait_done(bc);
    chk("divwrap_lo", lo, 32'h80000000);
    chk("divwrap_hi", hi, 32'h0);

    // Start and MTLO while busy are ignored
    issue(op_mult, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; mdop = op_divu; busa = 32'd100; busb = 32'd3;
    @(posedge clk);
    #2 mdop = op_mtlo; busa = 32'h1234;
    @(posedge clk);
    #2 start = 1'b0; mdop = 3'd0;
    chk("ign_busy", busy, 1);
    chk("ign_lo_hold", lo, 32'h80000000);
    wait_done(bc);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd30);

    // Back-to-back: new Start in the Done cycle
    issue(op_multu, 32'h10, 32'h10);
    repeat (32) @(posedge clk);
    #2;
    chk("b2b_done_cycle", done, 1);
    start = 1'b1; mdop = op_divu; busa = 32'd100; busb = 32'd7;
    @(posedge clk);
    #2 start = 1'b0; mdop = 3'd0;
    chk("b2b_accepted", busy, 1);
    chk("b2b_first_lo", lo, 32'h100);
    wait_done(bc);
    chk("b2b_latency", bc, 32);
    chk("b2b_lo", lo, 32'd14);
    chk("b2b_hi", hi, 32'd2);

    // Randomized traffic: ALU checked each cycle, mul/div via the compare process
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      start   = ($urandom_range(0, 5) == 0);
      mdop    = 3'($urandom_range(0, 7));
      busa    = pick();
      busb    = pick();
      aluctrl = 4'($urandom_range(0, 15));
      #1;
      r = alu_ref(aluctrl, busa, busb);
      chk("rnd_alu_w", busw, r[31:0]);
      chk("rnd_alu_ovf", ovf, r[32]);
      chk("rnd_alu_zero", zero, (r[31:0] == 32'h0));
    end
    start = 1'b0; mdop = 3'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", busy, 0);

    // MTHI / MTLO, then reset in the middle of a DIV
    issue(op_mthi, 32'hAAAA5555, 32'h0);
    chk("mthi", hi, 32'hAAAA5555);
    issue(op_mtlo, 32'h5555AAAA, 32'h0);
    chk("mtlo", lo, 32'h5555AAAA);
    issue(op_div, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("rst_no_done", dcount, 0);
    chk("rst_hi_after", hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
